// File: rtl/cpu_ctrl_pkg.sv
// Shared CPU control definitions: sequencer states, phase encodings and the
// opcodes that the alu and memory stages also decode.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    localparam logic [3:0] T_NONE  = 4'b0000;
    localparam logic [3:0] T_FETCH = 4'b0001;
    localparam logic [3:0] T_EXEC  = 4'b0010;
    localparam logic [3:0] T_MEM   = 4'b0100;
    localparam logic [3:0] T_WB    = 4'b1000;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_HALT = 6'b111111;

    function automatic logic uses_mem(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    // IDLE and HALT both present an all-zero phase vector to the datapath.
    function automatic logic [3:0] phase_of(input state_t s);
        case (s)
            FETCH:   return T_FETCH;
            EXEC:    return T_EXEC;
            MEM:     return T_MEM;
            WB:      return T_WB;
            default: return T_NONE;
        endcase
    endfunction

endpackage

// File: rtl/phase_ctrl_if.sv
// Control/status bundle between the phase sequencer and the rest of the CPU.
interface phase_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic             step;
    logic [5:0]       op;
    logic             mem_ready;
    logic [3:0]       t;
    logic             busy;
    logic             halted;
    logic             mem_err;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output run, step, op, mem_ready,
        input  t, busy, halted, mem_err, instr_count
    );

    modport slave (
        input  run, step, op, mem_ready,
        output t, busy, halted, mem_err, instr_count
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Memory-phase wait counter; expired rises once MEM_TIMEOUT wait cycles have
// elapsed without the memory answering.
module mem_wait_timer #(
    parameter int TMO_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [TMO_W-1:0] count;

    // Saturates at the timeout value so a stalled sequencer never wraps it.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == TMO_W'(MEM_TIMEOUT));
endmodule

// File: rtl/phase_ctrl.sv
// Instruction-phase sequencer: drives the one-hot fetch/execute/memory/write-back
// vector with run/single-step control, memory wait timeout and HALT.
module phase_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int TMO_W       = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic        clk,
    input  logic        rst,
    phase_ctrl_if.slave bus
);
    state_t           state;
    state_t           state_next;
    logic             single;
    logic             single_next;
    logic             mem_err;
    logic             mem_err_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             tmr_clear;
    logic             tmr_enable;
    logic             tmr_expired;

    mem_wait_timer #(
        .TMO_W       (TMO_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            single  <= 1'b0;
            mem_err <= 1'b0;
            count   <= '0;
        end else begin
            state   <= state_next;
            single  <= single_next;
            mem_err <= mem_err_next;
            count   <= count_next;
        end
    end

    always_comb begin
        state_next   = state;
        single_next  = single;
        mem_err_next = mem_err;
        count_next   = count;
        tmr_clear    = 1'b0;
        tmr_enable   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.run) begin
                    state_next  = FETCH;
                    single_next = 1'b0;
                end else if (bus.step) begin
                    state_next  = FETCH;
                    single_next = 1'b1;
                end
            end
            FETCH: state_next = EXEC;
            EXEC: begin
                if (bus.op == OP_HALT) begin
                    state_next = HALT;
                end else if (uses_mem(bus.op)) begin
                    state_next = MEM;
                    tmr_clear  = 1'b1;
                end else begin
                    state_next = WB;
                end
            end
            // A ready arriving in the timeout cycle still completes the access.
            MEM: begin
                if (bus.mem_ready) begin
                    state_next = WB;
                end else if (tmr_expired) begin
                    state_next   = HALT;
                    mem_err_next = 1'b1;
                end else begin
                    tmr_enable = 1'b1;
                end
            end
            WB: begin
                count_next  = count + 1'b1;
                single_next = 1'b0;
                state_next  = (bus.run && !single) ? FETCH : IDLE;
            end
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    assign bus.t           = phase_of(state);
    assign bus.busy        = |phase_of(state);
    assign bus.halted      = (state == HALT);
    assign bus.mem_err     = mem_err;
    assign bus.instr_count = count;
endmodule

// File: tb/tb_phase_ctrl.sv
// Randomized self-checking bench for phase_ctrl; expected phases come from a
// per-instruction trace model built from the instruction mix.
module tb_phase_ctrl;
    import cpu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_count;

    logic [3:0]  q_t[$];
    logic [5:0]  q_op[$];
    logic        q_rdy[$];

    always #5 clk = ~clk;

    phase_ctrl_if #(.CNT_W(32)) bus ();

    phase_ctrl #(
        .TMO_W       (4),
        .MEM_TIMEOUT (15),
        .CNT_W       (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_cycle(input logic [3:0] ph, input logic [5:0] opc, input logic rdy);
        q_t.push_back(ph);
        q_op.push_back(opc);
        q_rdy.push_back(rdy);
    endfunction

    // A memory op spends waits+1 cycles in MEM, ready only on the last one.
    function automatic void plan_instr(input logic [5:0] opc, input int waits);
        push_cycle(4'b0001, opc, 1'($urandom));
        push_cycle(4'b0010, opc, 1'($urandom));
        if (opc == OP_LW || opc == OP_SW) begin
            for (int w = 0; w <= waits; w++) push_cycle(4'b0100, opc, w == waits);
        end
        push_cycle(4'b1000, opc, 1'($urandom));
    endfunction

    function automatic logic [5:0] rand_alu();
        logic [5:0] o;
        do o = 6'($urandom); while (o == OP_LW || o == OP_SW || o == OP_HALT);
        return o;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.run = 1'b0;
        bus.step = 1'b0;
        bus.op = 6'd0;
        bus.mem_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_count = 32'd0;
        q_t.delete();
        q_op.delete();
        q_rdy.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.run = 1'b1;
        bus.step = 1'b1;
        bus.op = OP_LW;
        bus.mem_ready = 1'b0;
        tick();
        tick();
        total++;
        if (bus.t !== 4'b0000) begin bad++; $display("[TB] FAIL reset_t: got %b expected 0000", bus.t); end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        total++;
        if (bus.halted !== 1'b0) begin bad++; $display("[TB] FAIL reset_halted: got %b expected 0", bus.halted); end
        total++;
        if (bus.mem_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_err: got %b expected 0", bus.mem_err); end
        total++;
        if (bus.instr_count !== 32'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.instr_count); end
        rst = 1'b0;
        bus.run = 1'b0;
        bus.step = 1'b0;
    endtask

    task automatic test_alu_run();
        logic [3:0] exp_t;
        logic       saw_mem;
        do_reset();
        saw_mem = 1'b0;
        bus.run = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick();
            exp_t = (c % 3 == 0) ? 4'b0001 : ((c % 3 == 1) ? 4'b0010 : 4'b1000);
            total++;
            if (bus.t !== exp_t) begin bad++; $display("[TB] FAIL alu_t[%0d]: got %b expected %b", c, bus.t, exp_t); end
            total++;
            if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL alu_busy[%0d]: got %b expected 1", c, bus.busy); end
            if (bus.t[2] === 1'b1) saw_mem = 1'b1;
        end
        tick();
        total++;
        if (bus.instr_count !== 32'd3) begin bad++; $display("[TB] FAIL alu_count: got %0d expected 3", bus.instr_count); end
        total++;
        if (bus.t !== 4'b0001) begin bad++; $display("[TB] FAIL alu_no_bubble: got %b expected 0001", bus.t); end
        total++;
        if (saw_mem !== 1'b0) begin bad++; $display("[TB] FAIL alu_mem_phase: got %b expected 0", saw_mem); end
        bus.run = 1'b0;
    endtask

    task automatic test_random_stream();
        int r;
        do_reset();
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 2);
            if (r == 0) plan_instr(rand_alu(), 0);
            else plan_instr((r == 1) ? OP_LW : OP_SW, $urandom_range(0, 6));
        end
        bus.run = 1'b1;
        bus.op = q_op[0];
        for (int i = 0; i < q_t.size(); i++) begin
            tick();
            total++;
            if (bus.t !== q_t[i]) begin bad++; $display("[TB] FAIL stream_t[%0d]: got %b expected %b", i, bus.t, q_t[i]); end
            total++;
            if (bus.instr_count !== exp_count) begin bad++; $display("[TB] FAIL stream_count[%0d]: got %0d expected %0d", i, bus.instr_count, exp_count); end
            total++;
            if ({bus.busy, bus.halted, bus.mem_err} !== 3'b100) begin bad++; $display("[TB] FAIL stream_status[%0d]: got %b expected 100", i, {bus.busy, bus.halted, bus.mem_err}); end
            if (q_t[i] == 4'b1000) exp_count++;
            bus.op = q_op[i];
            bus.mem_ready = q_rdy[i];
            bus.step = (i == q_t.size() - 1) ? 1'b0 : 1'($urandom);
            if (i == q_t.size() - 1) bus.run = 1'b0;
        end
        tick();
        total++;
        if (bus.t !== 4'b0000) begin bad++; $display("[TB] FAIL stream_idle: got %b expected 0000", bus.t); end
        total++;
        if (bus.instr_count !== exp_count) begin bad++; $display("[TB] FAIL stream_final_count: got %0d expected %0d", bus.instr_count, exp_count); end
    endtask

    task automatic test_single_step();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            q_t.delete();
            q_op.delete();
            q_rdy.delete();
            if (k == 3) plan_instr(rand_alu(), 0);
            else plan_instr(OP_SW, (k == 0) ? 0 : $urandom_range(1, 4));
            bus.step = 1'b1;
            bus.op = q_op[0];
            for (int i = 0; i < q_t.size(); i++) begin
                tick();
                total++;
                if (bus.t !== q_t[i]) begin bad++; $display("[TB] FAIL step_t[%0d.%0d]: got %b expected %b", k, i, bus.t, q_t[i]); end
                if (q_t[i] == 4'b1000) exp_count++;
                bus.op = q_op[i];
                bus.mem_ready = q_rdy[i];
                bus.step = (i == q_t.size() - 1) ? 1'b0 : 1'($urandom);
            end
            repeat (3) tick();
            total++;
            if ({bus.t, bus.busy} !== 5'b00000) begin bad++; $display("[TB] FAIL step_idle[%0d]: got %b expected 00000", k, {bus.t, bus.busy}); end
            total++;
            if (bus.instr_count !== exp_count) begin bad++; $display("[TB] FAIL step_count[%0d]: got %0d expected %0d", k, bus.instr_count, exp_count); end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        plan_instr(OP_LW, 15);
        push_cycle(4'b0001, OP_LW, 1'b1);
        push_cycle(4'b0010, OP_LW, 1'b0);
        for (int w = 0; w < 16; w++) push_cycle(4'b0100, OP_LW, 1'b0);
        bus.run = 1'b1;
        bus.op = OP_LW;
        for (int i = 0; i < q_t.size(); i++) begin
            tick();
            total++;
            if (bus.t !== q_t[i]) begin bad++; $display("[TB] FAIL tmo_t[%0d]: got %b expected %b", i, bus.t, q_t[i]); end
            total++;
            if ({bus.halted, bus.mem_err} !== 2'b00) begin bad++; $display("[TB] FAIL tmo_early[%0d]: got %b expected 00", i, {bus.halted, bus.mem_err}); end
            if (q_t[i] == 4'b1000) exp_count++;
            bus.op = q_op[i];
            bus.mem_ready = q_rdy[i];
        end
        tick();
        total++;
        if ({bus.t, bus.busy} !== 5'b00000) begin bad++; $display("[TB] FAIL tmo_t_final: got %b expected 00000", {bus.t, bus.busy}); end
        total++;
        if ({bus.halted, bus.mem_err} !== 2'b11) begin bad++; $display("[TB] FAIL tmo_flags: got %b expected 11", {bus.halted, bus.mem_err}); end
        total++;
        if (bus.instr_count !== 32'd1) begin bad++; $display("[TB] FAIL tmo_count: got %0d expected 1", bus.instr_count); end
        for (int j = 0; j < 6; j++) begin
            bus.run = 1'($urandom);
            bus.step = 1'($urandom);
            bus.mem_ready = 1'b1;
            bus.op = rand_alu();
            tick();
            total++;
            if ({bus.t, bus.halted, bus.mem_err} !== 6'b000011) begin bad++; $display("[TB] FAIL tmo_sticky[%0d]: got %b expected 000011", j, {bus.t, bus.halted, bus.mem_err}); end
        end
        do_reset();
        total++;
        if ({bus.halted, bus.mem_err} !== 2'b00) begin bad++; $display("[TB] FAIL tmo_cleared: got %b expected 00", {bus.halted, bus.mem_err}); end
    endtask

    task automatic test_halt();
        do_reset();
        plan_instr(rand_alu(), 0);
        push_cycle(4'b0001, OP_HALT, 1'b0);
        push_cycle(4'b0010, OP_HALT, 1'b0);
        bus.run = 1'b1;
        for (int i = 0; i < q_t.size(); i++) begin
            tick();
            total++;
            if (bus.t !== q_t[i]) begin bad++; $display("[TB] FAIL halt_t[%0d]: got %b expected %b", i, bus.t, q_t[i]); end
            if (q_t[i] == 4'b1000) exp_count++;
            bus.op = q_op[i];
        end
        tick();
        total++;
        if ({bus.t, bus.busy, bus.halted, bus.mem_err} !== 7'b0000010) begin bad++; $display("[TB] FAIL halt_state: got %b expected 0000010", {bus.t, bus.busy, bus.halted, bus.mem_err}); end
        total++;
        if (bus.instr_count !== exp_count) begin bad++; $display("[TB] FAIL halt_count: got %0d expected %0d", bus.instr_count, exp_count); end
        bus.step = 1'b1;
        repeat (3) tick();
        total++;
        if ({bus.t, bus.halted} !== 5'b00001) begin bad++; $display("[TB] FAIL halt_sticky: got %b expected 00001", {bus.t, bus.halted}); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] seq[4];
        do_reset();
        for (int n = 0; n < 5; n++) plan_instr(rand_alu(), 0);
        push_cycle(4'b0001, OP_LW, 1'b0);
        push_cycle(4'b0010, OP_LW, 1'b0);
        push_cycle(4'b0100, OP_LW, 1'b0);
        push_cycle(4'b0100, OP_LW, 1'b0);
        bus.run = 1'b1;
        for (int i = 0; i < q_t.size(); i++) begin
            tick();
            total++;
            if (bus.t !== q_t[i]) begin bad++; $display("[TB] FAIL mid_t[%0d]: got %b expected %b", i, bus.t, q_t[i]); end
            bus.op = q_op[i];
            bus.mem_ready = q_rdy[i];
        end
        total++;
        if (bus.instr_count !== 32'd5) begin bad++; $display("[TB] FAIL mid_count_pre: got %0d expected 5", bus.instr_count); end
        rst = 1'b1;
        bus.run = 1'b0;
        tick();
        total++;
        if ({bus.t, bus.halted} !== 5'b00000) begin bad++; $display("[TB] FAIL mid_reset_t: got %b expected 00000", {bus.t, bus.halted}); end
        total++;
        if (bus.instr_count !== 32'd0) begin bad++; $display("[TB] FAIL mid_reset_count: got %0d expected 0", bus.instr_count); end
        rst = 1'b0;
        bus.run = 1'b1;
        bus.op = 6'd0;
        seq[0] = 4'b0001;
        seq[1] = 4'b0010;
        seq[2] = 4'b1000;
        seq[3] = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (bus.t !== seq[c]) begin bad++; $display("[TB] FAIL drop_run_t[%0d]: got %b expected %b", c, bus.t, seq[c]); end
            if (c == 1) bus.run = 1'b0;
        end
        total++;
        if (bus.instr_count !== 32'd1) begin bad++; $display("[TB] FAIL drop_run_count: got %0d expected 1", bus.instr_count); end
        tick();
        total++;
        if (bus.t !== 4'b0000) begin bad++; $display("[TB] FAIL drop_run_idle: got %b expected 0000", bus.t); end
    endtask

    initial begin
        $display("[TB] phase_ctrl bench start");
        test_reset();
        test_alu_run();
        test_random_stream();
        test_single_step();
        test_timeout();
        test_halt();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
